register_entry_controller: RTL and testbench
============================================

// Module: register_entry_controller
// PURPOSE
//  Front-panel writer for the 16-bit CPU register file, mirroring the hex display path.
//  Operator keys in up to 4 hex digits from nibble_in using debounced push buttons.
//  COMMIT writes the assembled word to the register chosen by reg_sel over a req/ack handshake.
//  entry_val drives the seven-segment path as a live preview.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable samples before a key level is accepted (10 ms @ 50 MHz)
//  CNT_W            19      width of each debounce counter; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clock        in   1   single clock; all state updates on rising edge
//  resetn       in   1   synchronous, active-low reset
//  nibble_in    in   4   hex digit from SW[3:0]; sampled on a DIGIT event
//  reg_sel      in   3   target register r1..r8 (0..7); sampled on a COMMIT event
//  key_digit_n  in   1   raw push button, active-low: shift in a digit
//  key_commit_n in   1   raw push button, active-low: write entry to register
//  key_clear_n  in   1   raw push button, active-low: discard entry
//  wr_req       out  1   write request to register file; held until acknowledged
//  wr_ack       in   1   register file accepts the write on a cycle with wr_req&&wr_ack
//  wr_addr      out  3   register index; stable while wr_req=1
//  wr_data      out  16  value to write; stable while wr_req=1
//  entry_val    out  16  digits entered so far, right-justified
//  digit_count  out  3   digits entered, 0..4, saturating
//  busy         out  1   1 in WRITE state
// BEHAVIOUR
//  Reset (resetn=0 at an edge): state=IDLE.
//   Output reset values: entry_val=0, digit_count=0, wr_req=0, wr_addr=0, wr_data=0, busy=0.
//   Debounced key levels reset to 1 (released); debounce counters reset to 0.
//  Key input path, per key:
//   - 2-flop synchroniser.
//   - Counter increments while the synced level differs from the debounced level.
//   - Counter clears on any sample that matches the debounced level.
//   - At count DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
//   - A 1->0 flip of the debounced level emits a 1-cycle event pulse; release emits none.
//   - Glitch shorter than DEBOUNCE_CYCLES: no event.
//  FSM, states IDLE / ENTRY / WRITE:
//   IDLE  : digit_count=0.
//           DIGIT -> entry_val={12'h000,nibble_in}, count=1, go ENTRY.
//           COMMIT -> ignored (empty entry writes nothing).
//   ENTRY : DIGIT -> entry_val={entry_val[11:0],nibble_in}; count=min(count+1,4).
//             A 5th or later digit drops the oldest nibble; count stays 4.
//           COMMIT -> wr_addr=reg_sel, wr_data=entry_val, wr_req=1, busy=1, go WRITE.
//   WRITE : wr_req held; wr_addr and wr_data frozen.
//           Cycle with wr_ack=1 completes the write; next cycle: wr_req=0, busy=0,
//             entry_val=0, count=0, state IDLE.
//           wr_ack in the same cycle wr_req first rises is legal; minimum req pulse is 1 cycle.
//           DIGIT / COMMIT / CLEAR events in WRITE are dropped (not queued).
//           wr_ack while not in WRITE is ignored.
//  CLEAR (IDLE/ENTRY): entry_val=0, count=0, state IDLE.
//  Same-cycle priority: CLEAR > COMMIT > DIGIT; losing events are discarded.
//  Reset mid-WRITE: wr_req drops at that edge; no write is considered to have occurred.
//  All outputs are registered; no combinational path from inputs to outputs.
//  Latency: nibble/reg_sel sampled the cycle the event pulse is high; outputs update the next edge.
// STRUCTURE
//  Shared package/include (entry_defs): FSM state localparams (IDLE=2'd0, ENTRY=2'd1, WRITE=2'd2),
//   MAX_DIGITS=4, KEY_RELEASED=1'b1.
//  Sub-module key_debouncer (params DEBOUNCE_CYCLES, CNT_W; ports clock, resetn, key_n, press_pulse),
//   instantiated 3x. Top level holds the FSM, shift register and handshake registers.
// TESTING (bench: DEBOUNCE_CYCLES=4)
//  1. Entry and write: digits 1,2,3,4, reg_sel=5, COMMIT, wr_ack 3 cycles later.
//     -> wr_req high for 4 cycles; wr_addr=5, wr_data=16'h1234;
//        then entry_val=0, count=0, busy=0.
//  2. Overflow: digits A,B,C,D,E -> entry_val=16'hBCDE, digit_count=4.
//  3. Bounce: key_digit_n toggles every 2 cycles for 20 cycles, then settles low
//     -> exactly one DIGIT event, emitted 4 cycles after settling (post-synchroniser).
//  4. Simultaneous and busy events: CLEAR+COMMIT same cycle with entry=16'h00F7
//     -> no wr_req, entry_val=0.
//     DIGIT pressed during WRITE (wr_ack held low) -> wr_data unchanged, no count change.
//  5. Empty commit and stray ack: COMMIT in IDLE -> wr_req stays 0.
//     wr_ack pulsed in IDLE -> no state change.
//  6. Reset mid-WRITE: resetn=0 while wr_req=1 -> next edge wr_req=0,
//     all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/register_entry_controller_pkg.sv
// Shared definitions for the front-panel register entry controller:
// FSM states, entry width limits and the idle level of the raw push buttons.
package register_entry_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        WRITE = 2'd2
    } entry_state_e;

    localparam int   MAX_DIGITS   = 4;
    localparam logic KEY_RELEASED = 1'b1;

    // Digit counter saturates once the entry holds MAX_DIGITS nibbles.
    function automatic logic [2:0] next_count(input logic [2:0] count);
        return (count >= 3'(MAX_DIGITS)) ? 3'(MAX_DIGITS) : count + 3'd1;
    endfunction

endpackage

// File: rtl/register_entry_controller_key_debouncer.sv
// One push-button conditioner: 2-flop synchroniser, stable-level debounce counter,
// and a single-cycle pulse on each accepted press (release produces nothing).
module key_debouncer
    import register_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic press_pulse
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= KEY_RELEASED;
            sync2_q <= KEY_RELEASED;
            level_q <= KEY_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                pulse_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/register_entry_controller.sv
// Front-panel hex entry: debounced DIGIT/COMMIT/CLEAR keys build a 16-bit word
// that is written to the selected CPU register over a req/ack handshake.
module register_entry_controller
    import register_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  nibble_in,
    input  logic [2:0]  reg_sel,
    input  logic        key_digit_n,
    input  logic        key_commit_n,
    input  logic        key_clear_n,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] entry_val,
    output logic [2:0]  digit_count,
    output logic        busy
);

    logic [2:0] keys_n;
    logic [2:0] press;

    assign keys_n = {key_clear_n, key_commit_n, key_digit_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .clock      (clock),
            .resetn     (resetn),
            .key_n      (keys_n[gi]),
            .press_pulse(press[gi])
        );
    end

    logic ev_digit;
    logic ev_commit;
    logic ev_clear;

    assign ev_digit  = press[0];
    assign ev_commit = press[1];
    assign ev_clear  = press[2];

    entry_state_e state_q, state_d;
    logic [15:0]  entry_q, entry_d;
    logic [2:0]   count_q, count_d;
    logic         req_q, req_d;
    logic [2:0]   addr_q, addr_d;
    logic [15:0]  data_q, data_d;
    logic         busy_q, busy_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            entry_q <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                // An empty entry has nothing to commit, so COMMIT is simply dropped here.
                if (ev_clear) begin
                    entry_d = '0;
                    count_d = '0;
                end else if (!ev_commit && ev_digit) begin
                    entry_d = {12'h000, nibble_in};
                    count_d = 3'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (ev_clear) begin
                    entry_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (ev_commit) begin
                    addr_d  = reg_sel;
                    data_d  = entry_q;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end else if (ev_digit) begin
                    entry_d = {entry_q[11:0], nibble_in};
                    count_d = next_count(count_q);
                end
            end
            WRITE: begin
                // req is held for the whole state, so ack alone completes the transfer.
                if (wr_ack) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    entry_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_req      = req_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign entry_val   = entry_q;
    assign digit_count = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_register_entry_controller.sv
// Randomised and directed checks of the register entry controller against a
// transaction-level model of the entered word and the write handshake.
module tb_register_entry_controller;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  nibble_in;
    logic [2:0]  reg_sel;
    logic        key_digit_n;
    logic        key_commit_n;
    logic        key_clear_n;
    logic        wr_req;
    logic        wr_ack;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] entry_val;
    logic [2:0]  digit_count;
    logic        busy;

    register_entry_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (2)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .nibble_in   (nibble_in),
        .reg_sel     (reg_sel),
        .key_digit_n (key_digit_n),
        .key_commit_n(key_commit_n),
        .key_clear_n (key_clear_n),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .entry_val   (entry_val),
        .digit_count (digit_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the operator-visible entry.
    int model_entry = 0;
    int model_count = 0;

    // Handshake observation and automatic acknowledge.
    bit         ack_auto   = 1'b1;
    int         ack_delay  = 0;
    int         req_cycles = 0;
    int         req_len    = 0;
    int         stable_err = 0;
    int         busy_err   = 0;
    logic       req_prev   = 1'b0;
    logic [2:0] cap_addr   = '0;
    logic [15:0] cap_data  = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ack_auto) begin
            if (wr_req) begin
                wr_ack = (req_cycles == ack_delay);
                req_cycles++;
            end else begin
                wr_ack     = 1'b0;
                req_cycles = 0;
            end
        end else begin
            req_cycles = 0;
        end
    end

    always @(negedge clock) begin
        if (busy !== wr_req) busy_err++;
        if (wr_req) begin
            if (!req_prev) begin
                cap_addr = wr_addr;
                cap_data = wr_data;
            end else if (wr_addr !== cap_addr || wr_data !== cap_data) begin
                stable_err++;
            end
            req_len++;
        end
        req_prev = wr_req;
    end

    // keys: bit0 DIGIT, bit1 COMMIT, bit2 CLEAR; held well beyond the debounce window.
    task automatic press(input logic [2:0] keys);
        @(negedge clock);
        if (keys[0]) key_digit_n  = 1'b0;
        if (keys[1]) key_commit_n = 1'b0;
        if (keys[2]) key_clear_n  = 1'b0;
        repeat (8) @(negedge clock);
        key_digit_n  = 1'b1;
        key_commit_n = 1'b1;
        key_clear_n  = 1'b1;
        repeat (16) @(negedge clock);
    endtask

    task automatic check_entry(input string tag);
        check_eq({tag, "_entry"}, 32'(entry_val), 32'(model_entry));
        check_eq({tag, "_count"}, 32'(digit_count), 32'(model_count));
    endtask

    task automatic op_digit(input logic [3:0] nib);
        nibble_in = nib;
        press(3'b001);
        model_entry = (model_entry * 16 + int'(nib)) % 65536;
        model_count = (model_count < 4) ? model_count + 1 : 4;
        $display("digit %h -> entry %h count %0d", nib, entry_val, digit_count);
        check_entry("digit");
    endtask

    task automatic op_clear();
        press(3'b100);
        model_entry = 0;
        model_count = 0;
        $display("clear -> entry %h count %0d", entry_val, digit_count);
        check_entry("clear");
    endtask

    task automatic op_commit(input logic [2:0] sel, input int delay);
        reg_sel    = sel;
        ack_delay  = delay;
        req_len    = 0;
        stable_err = 0;
        busy_err   = 0;
        press(3'b010);
        $display("commit r%0d delay %0d -> req cycles %0d addr %0d data %h",
                 sel, delay, req_len, cap_addr, cap_data);
        if (model_count > 0) begin
            check_eq("commit_req_len", 32'(req_len), 32'(delay + 1));
            check_eq("commit_addr", 32'(cap_addr), 32'(sel));
            check_eq("commit_data", 32'(cap_data), 32'(model_entry));
        end else begin
            check_eq("empty_commit_req_len", 32'(req_len), 32'd0);
        end
        check_eq("commit_stable", 32'(stable_err), 32'd0);
        check_eq("commit_busy", 32'(busy_err), 32'd0);
        check_eq("commit_req_low", 32'(wr_req), 32'd0);
        model_entry = 0;
        model_count = 0;
        check_entry("commit");
    endtask

    initial begin
        int lat;
        resetn       = 1'b0;
        nibble_in    = 4'h0;
        reg_sel      = 3'd0;
        key_digit_n  = 1'b1;
        key_commit_n = 1'b1;
        key_clear_n  = 1'b1;
        wr_ack       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req", 32'(wr_req), 32'd0);
        check_eq("rst_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_data", 32'(wr_data), 32'd0);
        check_eq("rst_entry", 32'(entry_val), 32'd0);
        check_eq("rst_count", 32'(digit_count), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);

        // Entry and write with a late acknowledge.
        op_digit(4'h1);
        op_digit(4'h2);
        op_digit(4'h3);
        op_digit(4'h4);
        check_eq("t1_entry", 32'(entry_val), 32'h1234);
        op_commit(3'd5, 3);

        // Fifth digit pushes the oldest nibble out.
        op_digit(4'hA);
        op_digit(4'hB);
        op_digit(4'hC);
        op_digit(4'hD);
        op_digit(4'hE);
        check_eq("ovf_entry", 32'(entry_val), 32'hBCDE);
        check_eq("ovf_count", 32'(digit_count), 32'd4);

        // Bouncing key: short runs never qualify; one event once settled low.
        op_clear();
        nibble_in = 4'h9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            key_digit_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clock);
        check_eq("bounce_quiet", 32'(digit_count), 32'd0);
        key_digit_n = 1'b0;
        lat = 0;
        while (lat < 20 && digit_count == 3'd0) begin
            @(posedge clock);
            #1;
            lat++;
        end
        // 2 synchroniser edges + 4 stable samples + 1 output register edge.
        check_eq("bounce_latency", 32'(lat), 32'd7);
        repeat (10) @(negedge clock);
        key_digit_n = 1'b1;
        repeat (16) @(negedge clock);
        model_entry = 9;
        model_count = 1;
        check_entry("bounce");

        // CLEAR beats COMMIT in the same cycle.
        op_clear();
        op_digit(4'hF);
        op_digit(4'h7);
        check_eq("sim_pre_entry", 32'(entry_val), 32'h00F7);
        req_len = 0;
        press(3'b110);
        model_entry = 0;
        model_count = 0;
        $display("clear+commit -> req cycles %0d entry %h", req_len, entry_val);
        check_eq("sim_no_req", 32'(req_len), 32'd0);
        check_entry("sim");

        // DIGIT while the write is pending is dropped.
        op_digit(4'h3);
        op_digit(4'hC);
        ack_auto = 1'b0;
        reg_sel  = 3'd2;
        press(3'b010);
        check_eq("busy_req", 32'(wr_req), 32'd1);
        check_eq("busy_flag", 32'(busy), 32'd1);
        nibble_in = 4'h5;
        press(3'b001);
        $display("digit during write -> data %h count %0d", wr_data, digit_count);
        check_eq("busy_data", 32'(wr_data), 32'h003C);
        check_eq("busy_addr", 32'(wr_addr), 32'd2);
        check_eq("busy_count", 32'(digit_count), 32'd2);
        check_eq("busy_req_held", 32'(wr_req), 32'd1);
        wr_ack = 1'b1;
        @(negedge clock);
        wr_ack = 1'b0;
        model_entry = 0;
        model_count = 0;
        check_eq("busy_done_req", 32'(wr_req), 32'd0);
        check_eq("busy_done_busy", 32'(busy), 32'd0);
        check_entry("busy_done");
        ack_auto = 1'b1;

        // Empty commit and stray acknowledge in IDLE.
        op_clear();
        op_commit(3'd3, 0);
        ack_auto = 1'b0;
        wr_ack   = 1'b1;
        repeat (3) @(negedge clock);
        wr_ack = 1'b0;
        @(negedge clock);
        check_eq("stray_req", 32'(wr_req), 32'd0);
        check_entry("stray");
        ack_auto = 1'b1;
        op_digit(4'h6);

        // Reset while the write request is up.
        ack_auto     = 1'b0;
        reg_sel      = 3'd7;
        key_commit_n = 1'b0;
        lat = 0;
        while (lat < 30 && wr_req !== 1'b1) begin
            @(negedge clock);
            lat++;
        end
        check_eq("rstw_req_up", 32'(wr_req), 32'd1);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        $display("reset mid-write -> req %0d entry %h count %0d", wr_req, entry_val, digit_count);
        check_eq("rstw_req", 32'(wr_req), 32'd0);
        check_eq("rstw_addr", 32'(wr_addr), 32'd0);
        check_eq("rstw_data", 32'(wr_data), 32'd0);
        check_eq("rstw_entry", 32'(entry_val), 32'd0);
        check_eq("rstw_count", 32'(digit_count), 32'd0);
        check_eq("rstw_busy", 32'(busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(negedge clock);
        key_commit_n = 1'b1;
        repeat (16) @(negedge clock);
        check_eq("rstw_idle_req", 32'(wr_req), 32'd0);
        ack_auto    = 1'b1;
        model_entry = 0;
        model_count = 0;
        op_digit(4'h4);

        // Random operation mix against the model.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                op_digit(4'($urandom_range(0, 15)));
            end else if (r < 85) begin
                op_commit(3'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
            end else begin
                op_clear();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
